// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder feeding 16-word block bursts to the hash core
module sha256_padder #(
  parameter int BUSY_GUARD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic        in_ready,
  output logic [31:0] data,
  output logic        write_enable,
  output logic        first_block,
  output logic        last_block,
  input  logic        core_busy
);

  typedef enum logic [2:0] {FILL, PAD, WAIT, EMIT, GUARD} state_t;

  localparam logic [7:0] GUARD_LAST = (BUSY_GUARD > 1) ? 8'(BUSY_GUARD - 1) : 8'd0;

  state_t      state, state_n;
  logic [31:0] blk [16];
  logic [3:0]  widx;
  logic [63:0] nbytes_tot;
  logic [63:0] length;
  logic [7:0]  gcnt;
  logic        marker_pending, marker_placed, len_hi_done, is_final, pad_more, msg_first;
  logic [2:0]  nb;
  logic [31:0] last_word, pad_word, data_n;
  logic        accept, pad_len_lo, guard_done, we_n, fb_n, lb_n;

  assign accept     = in_valid && in_ready && (state == FILL);
  assign nb         = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign length     = {nbytes_tot[60:0], 3'b000};
  assign pad_len_lo = !marker_pending && (widx == 4'd15) && len_hi_done;
  assign guard_done = (gcnt >= GUARD_LAST);

  // Final word: keep the valid bytes, drop the rest, and drop the marker in place when it fits.
  always_comb begin
    last_word = in_data;
    case (nb)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = (in_data & 32'hFF00_0000) | 32'h0080_0000;
      3'd2:    last_word = (in_data & 32'hFFFF_0000) | 32'h0000_8000;
      3'd3:    last_word = (in_data & 32'hFFFF_FF00) | 32'h0000_0080;
      default: last_word = in_data;
    endcase
  end

  always_comb begin
    pad_word = '0;
    if (marker_pending)                         pad_word = 32'h8000_0000;
    else if (widx == 4'd14 && marker_placed)    pad_word = length[63:32];
    else if (pad_len_lo)                        pad_word = length[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_n;
  end

  // widx doubles as the emit index: it is always 0 when a block reaches WAIT.
  always_comb begin
    state_n = state;
    data_n  = '0;
    we_n    = 1'b0;
    fb_n    = 1'b0;
    lb_n    = 1'b0;
    case (state)
      FILL: begin
        if (accept && (in_last || widx == 4'd15))
          state_n = (widx == 4'd15) ? WAIT : PAD;
      end
      PAD: begin
        if (widx == 4'd15) state_n = WAIT;
      end
      WAIT: begin
        if (!core_busy) begin
          state_n = EMIT;
          data_n  = blk[widx];
          we_n    = 1'b1;
          fb_n    = msg_first;
          lb_n    = is_final;
        end
      end
      EMIT: begin
        data_n = blk[widx];
        we_n   = 1'b1;
        if (widx == 4'd15) state_n = GUARD;
      end
      GUARD: begin
        if (guard_done) state_n = pad_more ? PAD : FILL;
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready       <= 1'b0;
      data           <= '0;
      write_enable   <= 1'b0;
      first_block    <= 1'b0;
      last_block     <= 1'b0;
      widx           <= '0;
      nbytes_tot     <= '0;
      gcnt           <= '0;
      marker_pending <= 1'b0;
      marker_placed  <= 1'b0;
      len_hi_done    <= 1'b0;
      is_final       <= 1'b0;
      pad_more       <= 1'b0;
      msg_first      <= 1'b1;
    end else begin
      in_ready     <= (state_n == FILL);
      data         <= data_n;
      write_enable <= we_n;
      first_block  <= fb_n;
      last_block   <= lb_n;
      case (state)
        FILL: begin
          if (accept) begin
            widx       <= widx + 4'd1;
            nbytes_tot <= nbytes_tot + (in_last ? {61'd0, nb} : 64'd4);
            if (in_last) begin
              if (nb == 3'd4) marker_pending <= 1'b1;
              else            marker_placed  <= 1'b1;
              // A final word that fills the block leaves all padding for the next block.
              if (widx == 4'd15) pad_more <= 1'b1;
            end
          end
        end
        PAD: begin
          widx <= widx + 4'd1;
          if (marker_pending) begin
            marker_pending <= 1'b0;
            marker_placed  <= 1'b1;
          end else if (widx == 4'd14 && marker_placed) begin
            len_hi_done <= 1'b1;
          end else if (pad_len_lo) begin
            is_final <= 1'b1;
          end
          if (widx == 4'd15 && !pad_len_lo) pad_more <= 1'b1;
        end
        WAIT: begin
          if (!core_busy) begin
            widx      <= widx + 4'd1;
            msg_first <= 1'b0;
          end
        end
        EMIT: begin
          widx <= widx + 4'd1;
          gcnt <= '0;
        end
        GUARD: begin
          gcnt <= gcnt + 8'd1;
          if (guard_done) begin
            pad_more <= 1'b0;
            if (is_final) begin
              is_final      <= 1'b0;
              msg_first     <= 1'b1;
              nbytes_tot    <= '0;
              marker_placed <= 1'b0;
              len_hi_done   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept)          blk[widx] <= in_last ? last_word : in_data;
    else if (state == PAD) blk[widx] <= pad_word;
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - directed self-checking bench for sha256_padder
module tb_sha256_padder;
  logic        clk, reset, in_valid, in_last, core_busy;
  logic        in_ready, write_enable, first_block, last_block;
  logic [31:0] in_data, data;
  logic [2:0]  in_nbytes;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] wq[$];
  bit          fq[$], lq[$];
  int          starts[$], runs[$];
  int          run = 0;
  int          idle_bad = 0;
  int          acc_cyc[32];
  bit          send_ok, send_done;

  sha256_padder #(.BUSY_GUARD(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_nbytes(in_nbytes), .in_ready(in_ready), .data(data), .write_enable(write_enable),
    .first_block(first_block), .last_block(last_block), .core_busy(core_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Burst monitor: records every emitted word, its flags, burst start cycle and burst length.
  always @(negedge clk) begin
    if (write_enable) begin
      wq.push_back(data);
      fq.push_back(first_block);
      lq.push_back(last_block);
      if (run == 0) starts.push_back(cyc);
      run++;
    end else begin
      if (run != 0) runs.push_back(run);
      run = 0;
      if (data !== 32'd0 || first_block !== 1'b0 || last_block !== 1'b0) idle_bad++;
    end
  end

  function automatic logic [31:0] pat(input int i);
    return {i[7:0], 8'hA5, ~i[7:0], 8'h3C};
  endfunction

  task automatic clear_cap();
    wq.delete(); fq.delete(); lq.delete(); starts.delete(); runs.delete();
    idle_bad = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb, output int acc);
    in_data = d; in_last = last; in_nbytes = nb; in_valid = 1'b1; acc = -1;
    for (int k = 0; k < 400; k++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input int n, input logic [2:0] last_nb, output bit ok);
    int a;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_word(pat(i), i == n - 1, (i == n - 1) ? last_nb : 3'd4, a);
      acc_cyc[i] = a;
      if (a < 0) ok = 1'b0;
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk); #1;
      if (wq.size() >= n && !write_enable) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_nbytes = '0; core_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", write_enable); end
    checks++; if (data !== 32'd0)        begin errors++; $display("FAIL rst_data got %h want 0", data); end
    checks++; if (first_block !== 1'b0 || last_block !== 1'b0)
      begin errors++; $display("FAIL rst_flags got %b%b want 00", first_block, last_block); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready got %b want 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %b want 1", in_ready); end
  endtask

  task automatic test_abc(input string name);
    bit ok; int a;
    logic [31:0] exp[16];
    clear_cap();
    for (int i = 0; i < 16; i++) exp[i] = 32'd0;
    exp[0] = 32'h6162_6380; exp[15] = 32'h0000_0018;
    send_word(32'h6162_6300, 1'b1, 3'd3, a);
    wait_words(16, ok);
    checks++;
    if (!ok || a < 0) begin errors++; $display("FAIL %s_timeout words=%0d want 16", name, wq.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL %s_w%0d got %h want %h", name, i, wq[i], exp[i]); end
        checks++; if (fq[i] !== (i == 0) || lq[i] !== (i == 0))
          begin errors++; $display("FAIL %s_flags_w%0d got %b%b want %b%b", name, i, fq[i], lq[i], i == 0, i == 0); end
      end
      checks++; if (runs[0] !== 16) begin errors++; $display("FAIL %s_run got %0d want 16", name, runs[0]); end
      checks++; if (starts[0] - a !== 16) begin errors++; $display("FAIL %s_latency got %0d want 16", name, starts[0] - a); end
      checks++; if (idle_bad !== 0) begin errors++; $display("FAIL %s_idle_outputs got %0d want 0", name, idle_bad); end
    end
  endtask

  task automatic test_empty();
    bit ok; int a;
    clear_cap();
    send_word(32'hFFFF_FFFF, 1'b1, 3'd0, a);
    wait_words(16, ok);
    checks++;
    if (!ok || a < 0) begin errors++; $display("FAIL empty_timeout words=%0d want 16", wq.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (wq[i] !== ((i == 0) ? 32'h8000_0000 : 32'd0))
          begin errors++; $display("FAIL empty_w%0d got %h want %h", i, wq[i], (i == 0) ? 32'h8000_0000 : 32'd0); end
      end
      checks++; if (fq[0] !== 1'b1 || lq[0] !== 1'b1) begin errors++; $display("FAIL empty_flags got %b%b want 11", fq[0], lq[0]); end
    end
  endtask

  task automatic test_56_bytes();
    bit ok, sok;
    logic [31:0] exp[32];
    for (int i = 0; i < 32; i++) exp[i] = (i < 14) ? pat(i) : 32'd0;
    exp[14] = 32'h8000_0000; exp[31] = 32'h0000_01C0;
    clear_cap();
    send_msg(14, 3'd4, sok);
    wait_words(32, ok);
    checks++;
    if (!ok || !sok) begin errors++; $display("FAIL b56_timeout words=%0d want 32", wq.size()); end
    else begin
      for (int i = 0; i < 32; i++) begin
        checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL b56_w%0d got %h want %h", i, wq[i], exp[i]); end
        checks++; if (fq[i] !== (i == 0) || lq[i] !== (i == 16))
          begin errors++; $display("FAIL b56_flags_w%0d got %b%b want %b%b", i, fq[i], lq[i], i == 0, i == 16); end
      end
      checks++; if (runs.size() !== 2 || runs[0] !== 16 || runs[1] !== 16)
        begin errors++; $display("FAIL b56_runs got %0d bursts want 2x16", runs.size()); end
    end
  endtask

  task automatic test_64_bytes();
    bit ok, sok;
    logic [31:0] exp[32];
    for (int i = 0; i < 32; i++) exp[i] = (i < 16) ? pat(i) : 32'd0;
    exp[16] = 32'h8000_0000; exp[31] = 32'h0000_0200;
    clear_cap();
    send_msg(16, 3'd4, sok);
    wait_words(32, ok);
    checks++;
    if (!ok || !sok) begin errors++; $display("FAIL b64_timeout words=%0d want 32", wq.size()); end
    else begin
      for (int i = 0; i < 32; i++) begin
        checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL b64_w%0d got %h want %h", i, wq[i], exp[i]); end
        checks++; if (fq[i] !== (i == 0) || lq[i] !== (i == 16))
          begin errors++; $display("FAIL b64_flags_w%0d got %b%b want %b%b", i, fq[i], lq[i], i == 0, i == 16); end
      end
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    int we_seen, rdy_seen, fall_cyc;
    logic [31:0] exp[32];
    for (int i = 0; i < 32; i++) exp[i] = (i < 19) ? pat(i) : 32'd0;
    exp[19] = 32'h13A5_8000; exp[31] = 32'h0000_0270;
    clear_cap();
    core_busy = 1'b0; send_done = 1'b0;
    fork
      begin send_msg(20, 3'd2, send_ok); send_done = 1'b1; end
    join_none
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); #1;
      if (runs.size() >= 1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL busy_first_burst_timeout runs=%0d want 1", runs.size()); end
    core_busy = 1'b1;
    we_seen = 0; rdy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (write_enable) we_seen++;
      if (send_done && in_ready) rdy_seen++;
    end
    checks++; if (we_seen !== 0)    begin errors++; $display("FAIL busy_we_held got %0d cycles want 0", we_seen); end
    checks++; if (send_done !== 1'b1 || send_ok !== 1'b1) begin errors++; $display("FAIL busy_send got %b%b want 11", send_done, send_ok); end
    checks++; if (rdy_seen !== 0)   begin errors++; $display("FAIL busy_in_ready got %0d cycles want 0", rdy_seen); end
    #1;
    core_busy = 1'b0;
    fall_cyc = cyc;
    wait_words(32, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_timeout words=%0d want 32", wq.size()); end
    else begin
      checks++; if (starts[1] - fall_cyc !== 1) begin errors++; $display("FAIL busy_release_latency got %0d want 1", starts[1] - fall_cyc); end
      checks++; if (starts[0] - acc_cyc[15] !== 1) begin errors++; $display("FAIL busy_full_latency got %0d want 1", starts[0] - acc_cyc[15]); end
      checks++; if (runs[1] !== 16) begin errors++; $display("FAIL busy_run2 got %0d want 16", runs[1]); end
      for (int i = 0; i < 32; i++) begin
        checks++; if (wq[i] !== exp[i]) begin errors++; $display("FAIL busy_w%0d got %h want %h", i, wq[i], exp[i]); end
        checks++; if (fq[i] !== (i == 0) || lq[i] !== (i == 16))
          begin errors++; $display("FAIL busy_flags_w%0d got %b%b want %b%b", i, fq[i], lq[i], i == 0, i == 16); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok; int a;
    clear_cap();
    send_word(32'h6162_6300, 1'b1, 3'd3, a);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (wq.size() >= 8) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || wq[7] !== 32'd0) begin errors++; $display("FAIL midrst_reach_w7 got %0d words want 8", wq.size()); end
    reset = 1'b1;
    #1;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL midrst_we got %b want 0", write_enable); end
    checks++; if (data !== 32'd0)        begin errors++; $display("FAIL midrst_data got %h want 0", data); end
    checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL midrst_ready got %b want 0", in_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_abc("abc_after_reset");
  endtask

  initial begin
    test_reset();
    test_abc("abc");
    test_empty();
    test_56_bytes();
    test_64_bytes();
    test_busy_hold();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached without summary");
    $fatal(1);
  end
endmodule
